// File: rtl/sram_sync.sv
// Synchronous single-port SRAM with power-on zero-fill, registered read and range checking.
// Define SRAM_PARITY_EN to add a per-word even-parity bit with par_inj / par_err ports.
module sram_sync #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   output logic              rd_valid,
   output logic              addr_err,
`ifdef SRAM_PARITY_EN
   input  logic              par_inj,
   output logic              par_err,
`endif
   output logic              ready
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {
      ST_INIT,
      ST_IDLE
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  init_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              wr_en;

   // The address compare runs one bit wider so DEPTH == 2**ADDR_W is representable.
   assign in_range = ({1'b0, addr} < DEPTH_V);
   assign idx      = addr[IDX_W-1:0];
   assign wr_en    = (state == ST_IDLE) && req && we && in_range;

   // Storage: zero-filled during INIT, otherwise written by accepted in-range writes.
   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         mem[init_ptr] <= '0;
      end else if (wr_en) begin
         mem[idx] <= d_in;
      end
   end

`ifdef SRAM_PARITY_EN
   logic par_mem [DEPTH];

   // The parity bit makes each stored word plus its bit even; par_inj flips it deliberately.
   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         par_mem[init_ptr] <= 1'b0;
      end else if (wr_en) begin
         par_mem[idx] <= (^d_in) ^ par_inj;
      end
   end
`endif

   // Control FSM with registered read data and status strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_INIT;
         init_ptr <= '0;
         ready    <= 1'b0;
         d_out    <= '0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
`ifdef SRAM_PARITY_EN
         par_err  <= 1'b0;
`endif
      end else begin
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
`ifdef SRAM_PARITY_EN
         par_err  <= 1'b0;
`endif
         case (state)
            ST_INIT: begin
               if (init_ptr == LAST_IDX) begin
                  state <= ST_IDLE;
                  ready <= 1'b1;
               end else begin
                  init_ptr <= init_ptr + IDX_W'(1);
               end
            end
            ST_IDLE: begin
               if (req) begin
                  addr_err <= ~in_range;
                  if (!we) begin
                     rd_valid <= 1'b1;
                     d_out    <= in_range ? mem[idx] : '0;
`ifdef SRAM_PARITY_EN
                     par_err  <= in_range && ((^mem[idx]) != par_mem[idx]);
`endif
                  end
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_sync.sv
// Directed bench for sram_sync: a DEPTH=16 and a DEPTH=12 instance share stimulus, outputs checked per instance.
module tb_sram_sync;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       we = 1'b0;
   logic [3:0] addr = '0;
   logic [7:0] d_in = '0;

   logic [7:0] d_out, d_out12;
   logic       rd_valid, rd_valid12, addr_err, addr_err12, ready, ready12;
`ifdef SRAM_PARITY_EN
   logic       par_inj = 1'b0;
   logic       par_err, par_err12;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_sync #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .d_in(d_in),
      .d_out(d_out), .rd_valid(rd_valid), .addr_err(addr_err),
`ifdef SRAM_PARITY_EN
      .par_inj(par_inj), .par_err(par_err),
`endif
      .ready(ready)
   );

   sram_sync #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) u_dut12 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .d_in(d_in),
      .d_out(d_out12), .rd_valid(rd_valid12), .addr_err(addr_err12),
`ifdef SRAM_PARITY_EN
      .par_inj(par_inj), .par_err(par_err12),
`endif
      .ready(ready12)
   );

   typedef struct {
      logic       req;
      logic       we;
      logic [3:0] addr;
      logic [7:0] din;
      logic       rv;
      logic       ae;
      logic [7:0] dout;
      logic       rv12;
      logic       ae12;
      logic [7:0] dout12;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic w, input logic [3:0] a, input logic [7:0] dv);
      req = r; we = w; addr = a; d_in = dv;
      @(posedge clk); #1;
   endtask

   // Releases rst and walks the INIT window, issuing requests that must be ignored.
   task automatic init_check(input string tag);
      req = 1'b1; we = 1'b0; addr = 4'd13; d_in = 8'hEE;
      rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         chk($sformatf("%s ready16 c%0d", tag, i), ready, 32'(i == 16));
         chk($sformatf("%s ready12 c%0d", tag, i), ready12, 32'(i >= 12));
         chk($sformatf("%s rv16 c%0d", tag, i), rd_valid, 0);
         chk($sformatf("%s ae16 c%0d", tag, i), addr_err, 0);
         chk($sformatf("%s rv12 c%0d", tag, i), rd_valid12, 0);
         chk($sformatf("%s ae12 c%0d", tag, i), addr_err12, 0);
         req  = (i <= 11);
         we   = i[0];
         addr = 4'(i * 5);
      end
      req = 1'b0;
   endtask

   task automatic readback_zero(input string tag);
      for (int a = 0; a < 16; a++) begin
         cyc(1'b1, 1'b0, 4'(a), 8'h00);
         chk($sformatf("%s rv16 @%0d", tag, a), rd_valid, 1);
         chk($sformatf("%s dout16 @%0d", tag, a), d_out, 0);
         chk($sformatf("%s ae16 @%0d", tag, a), addr_err, 0);
         chk($sformatf("%s rv12 @%0d", tag, a), rd_valid12, 1);
         chk($sformatf("%s dout12 @%0d", tag, a), d_out12, 0);
         chk($sformatf("%s ae12 @%0d", tag, a), addr_err12, 32'(a >= 12));
      end
      cyc(1'b0, 1'b0, 4'd0, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      //              req   we    addr   din     rv   ae   dout    rv12 ae12 dout12
      vecs[0]  = '{1'b1, 1'b1, 4'd3,  8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5};
      vecs[2]  = '{1'b0, 1'b0, 4'd3,  8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5};
      vecs[3]  = '{1'b1, 1'b1, 4'd13, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5};
      vecs[4]  = '{1'b1, 1'b0, 4'd13, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00};
      vecs[5]  = '{1'b1, 1'b0, 4'd1,  8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
      vecs[6]  = '{1'b1, 1'b1, 4'd15, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
      vecs[7]  = '{1'b1, 1'b0, 4'd15, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00};
      vecs[8]  = '{1'b1, 1'b1, 4'd0,  8'h11, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00};
      vecs[9]  = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5};
      vecs[10] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h11};
      vecs[11] = '{1'b1, 1'b1, 4'd0,  8'h22, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 8'h11};
      vecs[12] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 8'h22};
      vecs[13] = '{1'b1, 1'b0, 4'd11, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
      vecs[14] = '{1'b1, 1'b0, 4'd12, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
      vecs[15] = '{1'b1, 1'b0, 4'd5,  8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
      vecs[16] = '{1'b1, 1'b0, 4'd7,  8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

      // Reset values while rst is held
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready16", ready, 0);
      chk("rst dout16", d_out, 0);
      chk("rst rv16", rd_valid, 0);
      chk("rst ae16", addr_err, 0);
      chk("rst ready12", ready12, 0);

      init_check("init1");
      readback_zero("zero1");

      // Directed vector table on both instances
      for (int i = 0; i < 17; i++) begin
         cyc(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].din);
         chk($sformatf("vec%0d rv16", i), rd_valid, vecs[i].rv);
         chk($sformatf("vec%0d ae16", i), addr_err, vecs[i].ae);
         chk($sformatf("vec%0d dout16", i), d_out, vecs[i].dout);
         chk($sformatf("vec%0d rv12", i), rd_valid12, vecs[i].rv12);
         chk($sformatf("vec%0d ae12", i), addr_err12, vecs[i].ae12);
         chk($sformatf("vec%0d dout12", i), d_out12, vecs[i].dout12);
      end

      // Fill with addr^0x5A, read half back, then pulse rst during a pending read
      for (int a = 0; a < 16; a++) cyc(1'b1, 1'b1, 4'(a), 8'(a) ^ 8'h5A);
      for (int a = 0; a < 8; a++) begin
         cyc(1'b1, 1'b0, 4'(a), 8'h00);
         chk($sformatf("fill rd @%0d", a), d_out, 32'(8'(a) ^ 8'h5A));
      end
      req = 1'b1; we = 1'b0; addr = 4'd8;
      #2 rst = 1'b1;
      #1;
      chk("midrst dout16", d_out, 0);
      chk("midrst rv16", rd_valid, 0);
      chk("midrst ready16", ready, 0);
      @(posedge clk); #1;
      init_check("init2");
      readback_zero("zero2");

`ifdef SRAM_PARITY_EN
      par_inj = 1'b1;
      cyc(1'b1, 1'b1, 4'd2, 8'h3C);
      par_inj = 1'b0;
      cyc(1'b1, 1'b1, 4'd4, 8'h3C);
      cyc(1'b1, 1'b0, 4'd2, 8'h00);
      chk("par rd@2 rv", rd_valid, 1);
      chk("par rd@2 dout", d_out, 32'h3C);
      chk("par rd@2 err", par_err, 1);
      cyc(1'b1, 1'b0, 4'd4, 8'h00);
      chk("par rd@4 err", par_err, 0);
      chk("par rd@4 dout", d_out, 32'h3C);
      cyc(1'b1, 1'b0, 4'd13, 8'h00);
      chk("par oor12 err", par_err12, 0);
      chk("par oor12 ae", addr_err12, 1);
      cyc(1'b0, 1'b0, 4'd0, 8'h00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
